// File: rtl/game_pkg.sv
// game_pkg: shared state encodings, scancodes and option tables for the round sequencer and scoring block
package game_pkg;
  typedef enum logic [1:0] {SELECT = 2'd0, COUNTDOWN = 2'd1, INGAME = 2'd2, FINISH = 2'd3} state_t;
  localparam logic [7:0] KEY_M     = 8'h3A;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_3     = 8'h26;
  localparam logic [7:0] KEY_4     = 8'h25;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [6:0] TIME_OPT [0:3] = '{7'd15, 7'd30, 7'd60, 7'd120};
  localparam logic [6:0] WORD_OPT [0:3] = '{7'd10, 7'd25, 7'd50, 7'd100};
  function automatic logic [6:0] opt_value(input logic mode, input logic [1:0] idx);
    return mode ? WORD_OPT[idx] : TIME_OPT[idx];
  endfunction
endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: keyboard/scoring inputs and round outputs of game_ctrl; best-score signals exist only with GAME_CTRL_BEST_EN
interface game_ctrl_if;
  import game_pkg::*;
  logic [127:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         finish;
  logic [9:0]   wpm;
  logic [9:0]   acc;
  state_t       state;
  logic         mode;
  logic [6:0]   value;
  logic [3:0]   cd_digit;
  logic         round_start;
  logic [9:0]   res_wpm;
  logic [9:0]   res_acc;
`ifdef GAME_CTRL_BEST_EN
  logic [9:0]   best_wpm;
  logic [1:0]   new_best;
  modport master (input key_down, last_change, key_valid, finish, wpm, acc,
                  output state, mode, value, cd_digit, round_start, res_wpm, res_acc, best_wpm, new_best);
  modport slave  (output key_down, last_change, key_valid, finish, wpm, acc,
                  input state, mode, value, cd_digit, round_start, res_wpm, res_acc, best_wpm, new_best);
`else
  modport master (input key_down, last_change, key_valid, finish, wpm, acc,
                  output state, mode, value, cd_digit, round_start, res_wpm, res_acc);
  modport slave  (output key_down, last_change, key_valid, finish, wpm, acc,
                  input state, mode, value, cd_digit, round_start, res_wpm, res_acc);
`endif
endinterface

// File: rtl/game_ctrl_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every TICK_DIV clocks, restartable with clr
module tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: TypeRacer round sequencer (menu keys, 3-2-1 countdown, result latching)
// Optional best-WPM tracking is enabled by defining GAME_CTRL_BEST_EN.
module game_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV  = 1000000,
  parameter int COUNT_SEC = 3,
  parameter int FIN_HOLD  = 50
) (
  input logic clk,
  input logic rst,
  game_ctrl_if.master g
);
  localparam int HW = FIN_HOLD > 0 ? $clog2(FIN_HOLD + 1) : 1;
  state_t state_q, state_d;
  logic mode_q, rs_q, tick, clr, start_d, fin_entry, press, is_enter, is_esc, cd_done, hold_full;
  logic [1:0] sel_q;
  logic [3:0] cd_q;
  logic [6:0] sub_q, rep_q;
  logic [7:0] code;
  logic [HW-1:0] hold_q;
  logic [9:0] res_wpm_q, res_acc_q;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .clr(clr), .tick(tick));
  // a make code for the key already latched in rep_q while it is still held is typematic repeat
  assign code      = g.last_change[7:0];
  assign press     = g.key_valid && !g.last_change[8] && g.key_down[g.last_change[6:0]]
                     && !(g.last_change[6:0] == rep_q && g.key_down[rep_q]);
  assign is_enter  = press && code == KEY_ENTER;
  assign is_esc    = press && code == KEY_ESC;
  assign cd_done   = tick && sub_q == 7'd99 && cd_q == 4'd1;
  assign hold_full = hold_q == HW'(FIN_HOLD);
  always_ff @(posedge clk)
    state_q <= rst ? SELECT : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      SELECT:    state_d = is_enter ? COUNTDOWN : SELECT;
      COUNTDOWN: state_d = is_esc ? SELECT : cd_done ? INGAME : COUNTDOWN;
      INGAME:    state_d = is_esc ? SELECT : g.finish ? FINISH : INGAME;
      FINISH:    state_d = (is_esc || (is_enter && hold_full)) ? SELECT : FINISH;
      default:   state_d = SELECT;
    endcase
  end
  always_comb begin
    clr       = state_q == SELECT && state_d == COUNTDOWN;
    start_d   = state_q == COUNTDOWN && state_d == INGAME;
    fin_entry = state_q == INGAME && state_d == FINISH;
  end
  always_ff @(posedge clk)
    if (rst) begin
      mode_q    <= 1'b0;
      sel_q     <= 2'd1;
      cd_q      <= 4'd0;
      sub_q     <= 7'd0;
      hold_q    <= '0;
      rep_q     <= 7'd0;
      rs_q      <= 1'b0;
      res_wpm_q <= 10'd0;
      res_acc_q <= 10'd0;
    end else begin
      rep_q  <= press ? g.last_change[6:0] : g.key_down[rep_q] ? rep_q : 7'd0;
      rs_q   <= start_d;
      mode_q <= (state_q == SELECT && press && code == KEY_M) ? !mode_q : mode_q;
      if (state_q == SELECT && press)
        sel_q <= code == KEY_1 ? 2'd0 : code == KEY_2 ? 2'd1 : code == KEY_3 ? 2'd2 : code == KEY_4 ? 2'd3 : sel_q;
      cd_q   <= clr ? 4'(COUNT_SEC) : state_d != COUNTDOWN ? 4'd0 : (tick && sub_q == 7'd99) ? cd_q - 4'd1 : cd_q;
      sub_q  <= clr ? 7'd0 : (state_q == COUNTDOWN && tick) ? (sub_q == 7'd99 ? 7'd0 : sub_q + 7'd1) : sub_q;
      hold_q <= fin_entry ? '0 : (state_q == FINISH && tick && !hold_full) ? hold_q + 1'b1 : hold_q;
      if (fin_entry) begin
        res_wpm_q <= g.wpm;
        res_acc_q <= g.acc;
      end
    end
  assign g.state       = state_q;
  assign g.mode        = mode_q;
  assign g.value       = opt_value(mode_q, sel_q);
  assign g.cd_digit    = cd_q;
  assign g.round_start = rs_q;
  assign g.res_wpm     = res_wpm_q;
  assign g.res_acc     = res_acc_q;
`ifdef GAME_CTRL_BEST_EN
  logic [9:0] best_q;
  logic       nb_q;
  always_ff @(posedge clk)
    if (rst) begin
      best_q <= 10'd0;
      nb_q   <= 1'b0;
    end else if (fin_entry && g.wpm > best_q) begin
      best_q <= g.wpm;
      nb_q   <= 1'b1;
    end else if (state_q == FINISH && state_d != FINISH) begin
      nb_q   <= 1'b0;
    end
  assign g.best_wpm = best_q;
  assign g.new_best = {1'b0, nb_q};
`endif
endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level round sequencer for the TypeRacer game. Drives `state`, `mode` and `value` into the typing/scoring datapath, and consumes its `finish`, `wpm` and `acc` outputs.
- Handles menu keys (mode toggle, target selection, start, abort), times the 3-2-1 countdown and latches the final round results for the FINISH screen.
- Sits between the PS/2 keyboard decoder and the counting/scoring block. Also feeds the seven-segment and VGA display logic.

Parameters:
- TICK_DIV, 1000000: clk cycles per 10 ms tick (100 MHz / 100 Hz).
- COUNT_SEC, 3: countdown length in seconds (1..9).
- FIN_HOLD, 50: ticks after entering FINISH during which Enter is ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- key_down  in  128  held-key bitmap from keyboard decoder
- last_change  in  9  scancode of last make/break; bit 8 = extended
- key_valid  in  1  one-cycle strobe, `last_change` updated
- finish  in  1  round-complete flag from scoring block
- wpm  in  10  live WPM from scoring block
- acc  in  10  live accuracy (%) from scoring block
- state  out  2  SELECT=0, COUNTDOWN=1, INGAME=2, FINISH=3
- mode  out  1  0 = timed round, 1 = word-count round
- value  out  7  seconds (mode 0) or word count (mode 1)
- cd_digit  out  4  countdown digit shown; 0 outside COUNTDOWN
- round_start  out  1  one-cycle pulse on COUNTDOWN->INGAME
- res_wpm  out  10  WPM latched at round end
- res_acc  out  10  accuracy latched at round end

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=SELECT, mode=0, sel_idx=1, so value=30.
  - cd_digit=0, round_start=0, res_wpm=0, res_acc=0.
  - Tick prescaler=0, repeat filter cleared.
  - Applies from any state, including mid-countdown.
- Press event:
  - Condition: key_valid=1, last_change[8]=0 and key_down[last_change[6:0]]=1.
  - Repeat filter: if the code equals rep_code and rep_code is still held, the press is ignored (typematic repeat).
  - A valid press sets rep_code to the code.
  - rep_code is cleared when key_down[rep_code]=0.
  - Extended codes are never presses.
- Scancodes:
  - M=0x3A toggles mode.
  - 1=0x16, 2=0x1E, 3=0x26, 4=0x25 set sel_idx to 0..3.
  - Enter=0x5A; Esc=0x76.
- Value tables (combinational from mode and sel_idx):
  - mode 0: 15, 30, 60, 120 seconds.
  - mode 1: 10, 25, 50, 100 words.
- Tick:
  - Free counter 0..TICK_DIV-1; tick=1 for one cycle at wrap.
  - Cleared on entry to COUNTDOWN so the first second is full length.
- State transitions:
  - SELECT: M and digit presses update the next cycle; mode toggle keeps sel_idx. Enter -> COUNTDOWN with cd_sec=COUNT_SEC and sub=0.
  - COUNTDOWN: on tick, sub increments; at sub=99, sub=0 and cd_sec decrements. When cd_sec=1 and sub wraps -> INGAME and round_start=1 for that cycle. Esc -> SELECT.
  - INGAME: finish=1 -> FINISH, latching res_wpm<=wpm and res_acc<=acc on the same edge. Esc -> SELECT with results unchanged.
  - FINISH: hold counter counts ticks, saturating at FIN_HOLD. Enter accepted only when hold=FIN_HOLD. Esc is accepted any time. Either key -> SELECT.
- Priorities and edge cases:
  - Esc beats finish in the same cycle.
  - mode, sel_idx and value are frozen outside SELECT. Keys other than Enter and Esc are ignored outside SELECT.
  - cd_digit=cd_sec in COUNTDOWN, 0 otherwise.
  - All outputs are registered except value, which decodes from registers.
- Latency:
  - Key press to state change: 1 clk.
  - Countdown total: COUNT_SEC*100*TICK_DIV clk from the Enter edge.

Optional Feature:
- Macro: GAME_CTRL_BEST_EN.
- When defined, adds outputs best_wpm[9:0] and new_best[1:0]:
  - On FINISH entry, if wpm>best_wpm then best_wpm<=wpm and new_best=1 until FINISH is exited.
  - best_wpm is cleared only by rst.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package game_pkg holds:
  - state encodings SELECT/COUNTDOWN/INGAME/FINISH;
  - scancode constants KEY_M, KEY_1..KEY_4, KEY_ENTER, KEY_ESC;
  - value tables TIME_OPT[0:3] and WORD_OPT[0:3].
- The scoring block imports the same state constants.
- One sub-module, tick_gen: parameter TICK_DIV; ports clk, rst, clr, tick.

Test Plan (bench uses TICK_DIV=4, FIN_HOLD=2):
- Reset, then idle 10 cycles -> state=0, mode=0, value=30, res_wpm=0, cd_digit=0.
- Press M, release, press 3 -> mode=1, value=50. Hold M with 5 repeated make strobes -> mode toggles once only.
- Enter in SELECT -> state=1, cd_digit 3->2->1 at 400-cycle intervals. At cycle 1200 after Enter -> state=2 with round_start high for exactly 1 cycle.
- In INGAME, wpm=87, acc=95, pulse finish -> state=3, res_wpm=87, res_acc=95. Enter 1 tick later is ignored; Enter after 3 ticks -> state=0.
- Esc during COUNTDOWN (cd_digit=2) -> state=0 next cycle. finish and Esc in the same INGAME cycle -> state=0 and results unchanged.
- Assert rst mid-COUNTDOWN with mode=1 -> next edge state=0, mode=0, value=30, cd_digit=0.
